muldiv_sequencer: RTL and testbench

- Sequences the shared multi-cycle mult and div units and the HI/LO register pair on behalf of the control unit.
- Accepts one-cycle requests (MULT, DIV, DIVM) and issues the unit start pulse. Holds the div source and HI/LO mux selects, counts the run cycles and strobes the HI/LO load.
- Reports completion or divide-by-zero back to the control unit, which stalls on busy instead of counting cycles itself.

---
 rtl/muldiv_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - sequencer for the shared mult/div units and HI/LO pair
//
// Purpose:
//   Accepts one-cycle MULT / DIV / DIVM requests from the control unit, pulses
//   the unit start line, holds the div source and HI/LO mux selects, counts the
//   unit run time and strobes the HI/LO load (or raises a divide-by-zero
//   exception). The control unit simply stalls while busy is high.
//
// Optional feature macro: MULDIV_EARLY_ZERO_EN
//   Defined   - a divide request with divisor==0 goes straight to EXC, no div_init.
//   Undefined - divisor is unused; zero is detected only via div_zero_in at the
//               end of the full DIV_CYCLES run.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-low reset
//   mult_req     in   start signed multiply A*B
//   div_req      in   start divide A/B
//   divm_req     in   start divide B/MDR
//   divisor      in   [31:0] divisor at the div unit's B input
//   div_zero_in  in   DivZero flag from the div unit
//   mult_init    out  one-cycle start pulse to the mult unit
//   div_init     out  one-cycle start pulse to the div unit
//   div_src_sel  out  div operand select: 0 = A/B, 1 = B/MDR
//   hilo_sel     out  HI/LO input select: 0 = div results, 1 = mult results
//   hl_load      out  HI/LO load strobe
//   busy         out  operation in progress, requests ignored
//   done         out  one-cycle completion pulse
//   div_zero_exc out  one-cycle divide-by-zero exception pulse

module muldiv_sequencer #(
   parameter int MULT_CYCLES = 32,
   parameter int DIV_CYCLES  = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mult_req,
   input  logic        div_req,
   input  logic        divm_req,
   input  logic [31:0] divisor,
   input  logic        div_zero_in,
   output logic        mult_init,
   output logic        div_init,
   output logic        div_src_sel,
   output logic        hilo_sel,
   output logic        hl_load,
   output logic        busy,
   output logic        done,
   output logic        div_zero_exc
);

   localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);
   localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_MULT_RUN = 3'd1,
      S_DIV_RUN  = 3'd2,
      S_WB       = 3'd3,
      S_EXC      = 3'd4
   } state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_mult_init;
   logic             r_div_init;
   logic             r_div_src_sel;
   logic             r_hilo_sel;
   logic             r_hl_load;
   logic             r_busy;
   logic             r_done;
   logic             r_div_zero_exc;

`ifdef MULDIV_EARLY_ZERO_EN
   logic w_divisor_zero;
   assign w_divisor_zero = (divisor == 32'd0);
`else
   // The divisor only matters for early zero detection.
   logic w_unused_divisor;
   assign w_unused_divisor = ^divisor;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state        <= S_IDLE;
         r_cnt          <= '0;
         r_mult_init    <= 1'b0;
         r_div_init     <= 1'b0;
         r_div_src_sel  <= 1'b0;
         r_hilo_sel     <= 1'b0;
         r_hl_load      <= 1'b0;
         r_busy         <= 1'b0;
         r_done         <= 1'b0;
         r_div_zero_exc <= 1'b0;
      end else begin
         // Pulse outputs default low; each is raised only on its entry edge.
         r_mult_init    <= 1'b0;
         r_div_init     <= 1'b0;
         r_hl_load      <= 1'b0;
         r_done         <= 1'b0;
         r_div_zero_exc <= 1'b0;

         case (r_state)
            S_IDLE: begin
               if (mult_req) begin
                  r_state     <= S_MULT_RUN;
                  r_cnt       <= MULT_LOAD;
                  r_hilo_sel  <= 1'b1;
                  r_mult_init <= 1'b1;
                  r_busy      <= 1'b1;
               end else if (div_req || divm_req) begin
                  // div_req outranks divm_req, so the source is MDR only without div_req.
                  r_div_src_sel <= ~div_req;
                  r_hilo_sel    <= 1'b0;
                  r_busy        <= 1'b1;
`ifdef MULDIV_EARLY_ZERO_EN
                  if (w_divisor_zero) begin
                     r_state        <= S_EXC;
                     r_done         <= 1'b1;
                     r_div_zero_exc <= 1'b1;
                  end else begin
                     r_state    <= S_DIV_RUN;
                     r_cnt      <= DIV_LOAD;
                     r_div_init <= 1'b1;
                  end
`else
                  r_state    <= S_DIV_RUN;
                  r_cnt      <= DIV_LOAD;
                  r_div_init <= 1'b1;
`endif
               end
            end

            S_MULT_RUN: begin
               if (r_cnt == '0) begin
                  r_state   <= S_WB;
                  r_hl_load <= 1'b1;
                  r_done    <= 1'b1;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end

            S_DIV_RUN: begin
               if (r_cnt == '0) begin
                  // The div unit's zero flag is only meaningful on its last cycle.
                  r_done <= 1'b1;
                  if (div_zero_in) begin
                     r_state        <= S_EXC;
                     r_div_zero_exc <= 1'b1;
                  end else begin
                     r_state   <= S_WB;
                     r_hl_load <= 1'b1;
                  end
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end

            S_WB, S_EXC: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end

            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign mult_init    = r_mult_init;
   assign div_init     = r_div_init;
   assign div_src_sel  = r_div_src_sel;
   assign hilo_sel     = r_hilo_sel;
   assign hl_load      = r_hl_load;
   assign busy         = r_busy;
   assign done         = r_done;
   assign div_zero_exc = r_div_zero_exc;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - randomized self-checking bench for muldiv_sequencer

module tb_muldiv_sequencer;

   localparam int MULT_CYCLES = 32;
   localparam int DIV_CYCLES  = 32;

   logic        clk;
   logic        reset;
   logic        mult_req;
   logic        div_req;
   logic        divm_req;
   logic [31:0] divisor;
   logic        div_zero_in;
   logic        mult_init;
   logic        div_init;
   logic        div_src_sel;
   logic        hilo_sel;
   logic        hl_load;
   logic        busy;
   logic        done;
   logic        div_zero_exc;

   muldiv_sequencer #(
      .MULT_CYCLES (MULT_CYCLES),
      .DIV_CYCLES  (DIV_CYCLES)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .mult_req     (mult_req),
      .div_req      (div_req),
      .divm_req     (divm_req),
      .divisor      (divisor),
      .div_zero_in  (div_zero_in),
      .mult_init    (mult_init),
      .div_init     (div_init),
      .div_src_sel  (div_src_sel),
      .hilo_sel     (hilo_sel),
      .hl_load      (hl_load),
      .busy         (busy),
      .done         (done),
      .div_zero_exc (div_zero_exc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp;
   int n_err;
   int edge_no;

   // Reference model: one operation is described by the edge it was accepted
   // on and the edge on which it completes; everything else follows from those.
   bit m_active;
   bit m_is_div;
   bit m_early;
   bit m_zero;
   int m_end;

   logic e_mult_init, e_div_init, e_div_src_sel, e_hilo_sel;
   logic e_hl_load, e_busy, e_done, e_exc;

   task automatic check(input string tag, input logic obs, input logic exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s edge %0d: got %b expected %b", tag, edge_no, obs, exp);
      end
   endtask

   task automatic compare_all();
      check("mult_init", mult_init, e_mult_init);
      check("div_init", div_init, e_div_init);
      check("div_src_sel", div_src_sel, e_div_src_sel);
      check("hilo_sel", hilo_sel, e_hilo_sel);
      check("hl_load", hl_load, e_hl_load);
      check("busy", busy, e_busy);
      check("done", done, e_done);
      check("div_zero_exc", div_zero_exc, e_exc);
   endtask

   task automatic model_clear();
      m_active = 0;
      e_mult_init = 0; e_div_init = 0; e_div_src_sel = 0; e_hilo_sel = 0;
      e_hl_load = 0; e_busy = 0; e_done = 0; e_exc = 0;
   endtask

   // Predict the outputs after the coming rising edge from the inputs now applied.
   task automatic model_edge();
      e_mult_init = 0; e_div_init = 0; e_hl_load = 0; e_done = 0; e_exc = 0;
      if (m_active) begin
         if (edge_no == m_end) begin
            if (m_is_div && !m_early) m_zero = div_zero_in;
            e_done    = 1;
            e_hl_load = !m_zero;
            e_exc     = m_zero;
         end
         e_busy = (edge_no <= m_end);
         // The edge after completion returns to idle without sampling requests.
         if (edge_no == m_end + 1) m_active = 0;
      end else if (mult_req) begin
         m_active = 1; m_is_div = 0; m_early = 0; m_zero = 0;
         m_end = edge_no + MULT_CYCLES;
         e_mult_init = 1; e_busy = 1; e_hilo_sel = 1;
      end else if (div_req || divm_req) begin
         m_active = 1; m_is_div = 1; m_zero = 0;
         e_busy = 1; e_hilo_sel = 0; e_div_src_sel = !div_req;
`ifdef MULDIV_EARLY_ZERO_EN
         m_early = (divisor == 32'd0);
`else
         m_early = 0;
`endif
         if (m_early) begin
            m_end = edge_no; m_zero = 1;
            e_done = 1; e_exc = 1;
         end else begin
            m_end = edge_no + DIV_CYCLES;
            e_div_init = 1;
         end
      end else begin
         e_busy = 0;
      end
      edge_no++;
   endtask

   // Called at a falling edge: apply inputs, predict, then observe next falling edge.
   task automatic run_cycle(input logic mr, input logic dr, input logic dmr,
                            input logic [31:0] dv, input logic dz);
      mult_req = mr; div_req = dr; divm_req = dmr; divisor = dv; div_zero_in = dz;
      model_edge();
      @(negedge clk);
      compare_all();
   endtask

   task automatic idle_cycles(input int n, input logic dz);
      for (int i = 0; i < n; i++) run_cycle(0, 0, 0, 32'd5, dz);
   endtask

   task automatic do_reset();
      reset = 0;
      mult_req = 0; div_req = 0; divm_req = 0; div_zero_in = 0;
      model_clear();
      #1;
      compare_all();
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         compare_all();
      end
      reset = 1;
   endtask

   initial begin
      n_cmp = 0; n_err = 0; edge_no = 0;
      reset = 0;
      mult_req = 0; div_req = 0; divm_req = 0; divisor = 32'd1; div_zero_in = 0;
      model_clear();
      @(negedge clk);
      compare_all();
      reset = 1;

      // Simultaneous mult/div: mult wins; div_req while busy is ignored.
      run_cycle(1, 1, 0, 32'd3, 0);
      idle_cycles(4, 0);
      run_cycle(0, 1, 0, 32'd3, 0);
      idle_cycles(40, 0);

      // DIVM with a non-zero divisor.
      run_cycle(0, 0, 1, 32'd7, 0);
      idle_cycles(40, 0);

      // Divide whose unit reports zero on the final run cycle.
      run_cycle(0, 1, 0, 32'd9, 1);
      idle_cycles(40, 1);

      // Divide with a zero divisor at the request edge.
      run_cycle(0, 1, 0, 32'd0, 0);
      idle_cycles(40, 0);

      // Reset in the middle of a multiply, then quiet cycles.
      run_cycle(1, 0, 0, 32'd2, 0);
      idle_cycles(9, 0);
      do_reset();
      idle_cycles(6, 0);

      // Randomized traffic.
      for (int i = 0; i < 2500; i++) begin
         logic [31:0] dv;
         dv = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
         run_cycle($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                   $urandom_range(0, 7) == 0, dv, $urandom_range(0, 2) == 0);
         if (i == 1234) do_reset();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
